// File: rtl/io_event_pkg.sv
// Shared constants and width helpers for the event capture queue.
package io_event_pkg;

    localparam int unsigned OVF_DROP_NEWEST      = 0;
    localparam int unsigned OVF_OVERWRITE_OLDEST = 1;

    function automatic int unsigned entry_width(input int unsigned ts_width,
                                                input int unsigned num_inputs);
        return ts_width + num_inputs;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/event_fifo_fwft.sv
// First-word-fall-through queue with occupancy count and optional overwrite-oldest on full.
module event_fifo_fwft
    import io_event_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned DEPTH     = 32,
    parameter logic        OVERWRITE = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              dout,
    output logic                          empty,
    output logic                          full,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          lost
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_write;
    logic             adv_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Overwrite on full advances the head with the tail, so count is unchanged.
    always_comb begin
        do_pop   = 1'b0;
        do_write = 1'b0;
        adv_rd   = 1'b0;
        lost     = 1'b0;
        do_pop   = rd_en && !empty;
        do_write = wr_en && (!full || do_pop || OVERWRITE);
        adv_rd   = do_pop || (wr_en && full && OVERWRITE);
        lost     = wr_en && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, adv_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_event_queue.sv
// Masked event capture with prescaled timestamp, FWFT queue and overflow accounting.
module io_event_queue
    import io_event_pkg::*;
#(
    parameter int unsigned NUM_INPUTS    = 8,
    parameter int unsigned FIFO_DEPTH    = 32,
    parameter int unsigned TS_WIDTH      = 16,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned OVERFLOW_MODE = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_b,
    input  logic [NUM_INPUTS-1:0]                         event_in,
    input  logic [NUM_INPUTS-1:0]                         event_mask,
    input  logic                                          rd_en,
    output logic [entry_width(TS_WIDTH, NUM_INPUTS)-1:0]  dout,
    output logic                                          empty,
    output logic                                          full,
    output logic [count_width(FIFO_DEPTH)-1:0]            count,
    output logic [7:0]                                    overflow_count,
    input  logic                                          clr_overflow
);

    localparam int unsigned EW = entry_width(TS_WIDTH, NUM_INPUTS);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]         presc;
    logic [TS_WIDTH-1:0]   ts;
    logic [NUM_INPUTS-1:0] masked;
    logic                  cap_valid;
    logic [EW-1:0]         cap_word;
    logic                  lost;

    assign masked = event_in & event_mask;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            presc <= '0;
            ts    <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            ts    <= ts + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cap_valid <= 1'b0;
            cap_word  <= '0;
        end else begin
            cap_valid <= |masked;
            cap_word  <= {ts, masked};
        end
    end

    event_fifo_fwft #(
        .WIDTH     (EW),
        .DEPTH     (FIFO_DEPTH),
        .OVERWRITE (OVERFLOW_MODE == OVF_OVERWRITE_OLDEST)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .wr_en   (cap_valid),
        .wr_data (cap_word),
        .rd_en   (rd_en),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .lost    (lost)
    );

    // A clear in the same cycle as a loss leaves that loss counted.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            overflow_count <= '0;
        end else if (clr_overflow) begin
            overflow_count <= {7'b0, lost};
        end else if (lost && (overflow_count != 8'hFF)) begin
            overflow_count <= overflow_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_io_event_queue.sv
// Directed bench: drop-newest and overwrite-oldest instances share all inputs.
module tb_io_event_queue;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [7:0]  event_in = '0;
    logic [7:0]  event_mask = 8'hFF;
    logic        rd_en = 1'b0;
    logic        clr_overflow = 1'b0;

    logic [15:0] dout0, dout1;
    logic        empty0, empty1, full0, full1;
    logic [2:0]  count0, count1;
    logic [7:0]  ovf0, ovf1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_event_queue #(
        .NUM_INPUTS(8), .FIFO_DEPTH(4), .TS_WIDTH(8), .TICK_DIV(1), .OVERFLOW_MODE(0)
    ) u_dut0 (
        .clk(clk), .rst_b(rst_b), .event_in(event_in), .event_mask(event_mask),
        .rd_en(rd_en), .dout(dout0), .empty(empty0), .full(full0), .count(count0),
        .overflow_count(ovf0), .clr_overflow(clr_overflow)
    );

    io_event_queue #(
        .NUM_INPUTS(8), .FIFO_DEPTH(4), .TS_WIDTH(8), .TICK_DIV(1), .OVERFLOW_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst_b(rst_b), .event_in(event_in), .event_mask(event_mask),
        .rd_en(rd_en), .dout(dout1), .empty(empty1), .full(full1), .count(count1),
        .overflow_count(ovf1), .clr_overflow(clr_overflow)
    );

    typedef struct {
        logic [7:0] ev;
        logic [7:0] mask;
        logic       rd;
        logic       clr;
        logic [2:0] c0;
        logic [7:0] h0;
        logic [7:0] o0;
        logic [2:0] c1;
        logic [7:0] h1;
        logic [7:0] o1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] ev, input logic [7:0] mask, input logic rd,
                       input logic clr, input logic [2:0] c0, input logic [7:0] h0,
                       input logic [7:0] o0, input logic [2:0] c1, input logic [7:0] h1,
                       input logic [7:0] o1);
        vec_t v;
        v.ev = ev; v.mask = mask; v.rd = rd; v.clr = clr;
        v.c0 = c0; v.h0 = h0; v.o0 = o0; v.c1 = c1; v.h1 = h1; v.o1 = o1;
        vecs.push_back(v);
    endtask

    initial begin
        // Masking and multi-bit capture
        add(8'h80, 8'h7F, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(8'h00, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(8'hC1, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(8'h00, 8'hFF, 0, 0, 1, 8'hC1, 0, 1, 8'hC1, 0);
        add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        // Overflow: drop-newest vs overwrite-oldest
        add(8'h01, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(8'h02, 8'hFF, 0, 0, 1, 8'h01, 0, 1, 8'h01, 0);
        add(8'h04, 8'hFF, 0, 0, 2, 8'h01, 0, 2, 8'h01, 0);
        add(8'h08, 8'hFF, 0, 0, 3, 8'h01, 0, 3, 8'h01, 0);
        add(8'h10, 8'hFF, 0, 0, 4, 8'h01, 0, 4, 8'h01, 0);
        add(8'h00, 8'hFF, 0, 0, 4, 8'h01, 1, 4, 8'h02, 1);
        add(8'h00, 8'hFF, 1, 0, 3, 8'h02, 1, 3, 8'h04, 1);
        add(8'h00, 8'hFF, 1, 0, 2, 8'h04, 1, 2, 8'h08, 1);
        add(8'h00, 8'hFF, 1, 0, 1, 8'h08, 1, 1, 8'h10, 1);
        add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 1, 0, 8'h00, 1);
        add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 1, 0, 8'h00, 1);
        add(8'h00, 8'hFF, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0);
        // Full with simultaneous push and pop
        add(8'h01, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        add(8'h02, 8'hFF, 0, 0, 1, 8'h01, 0, 1, 8'h01, 0);
        add(8'h04, 8'hFF, 0, 0, 2, 8'h01, 0, 2, 8'h01, 0);
        add(8'h08, 8'hFF, 0, 0, 3, 8'h01, 0, 3, 8'h01, 0);
        add(8'h20, 8'hFF, 0, 0, 4, 8'h01, 0, 4, 8'h01, 0);
        add(8'h00, 8'hFF, 1, 0, 4, 8'h02, 0, 4, 8'h02, 0);
        add(8'h00, 8'hFF, 1, 0, 3, 8'h04, 0, 3, 8'h04, 0);
        add(8'h00, 8'hFF, 1, 0, 2, 8'h08, 0, 2, 8'h08, 0);
        add(8'h00, 8'hFF, 1, 0, 1, 8'h20, 0, 1, 8'h20, 0);
        add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0);

        // Reset state and first event
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", {31'b0, empty0}, 1);
        check("rst_full", {31'b0, full0}, 0);
        check("rst_count", {29'b0, count0}, 0);
        check("rst_dout", {16'b0, dout0}, 0);
        check("rst_ovf", {24'b0, ovf0}, 0);
        rst_b = 1'b1;
        repeat (3) step();
        event_in = 8'h05;
        step();
        event_in = 8'h00;
        check("lat1_empty", {31'b0, empty0}, 1);
        step();
        check("first_empty", {31'b0, empty0}, 0);
        check("first_count", {29'b0, count0}, 1);
        check("first_dout", {16'b0, dout0}, 32'h0305);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pop_empty", {31'b0, empty0}, 1);
        check("pop_dout", {16'b0, dout0}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            event_in = vecs[i].ev;
            event_mask = vecs[i].mask;
            rd_en = vecs[i].rd;
            clr_overflow = vecs[i].clr;
            step();
            check($sformatf("v%0d count0", i), {29'b0, count0}, {29'b0, vecs[i].c0});
            check($sformatf("v%0d head0", i), {24'b0, dout0[7:0]}, {24'b0, vecs[i].h0});
            check($sformatf("v%0d ovf0", i), {24'b0, ovf0}, {24'b0, vecs[i].o0});
            check($sformatf("v%0d empty0", i), {31'b0, empty0}, {31'b0, (vecs[i].c0 == 0)});
            check($sformatf("v%0d full0", i), {31'b0, full0}, {31'b0, (vecs[i].c0 == 4)});
            check($sformatf("v%0d count1", i), {29'b0, count1}, {29'b0, vecs[i].c1});
            check($sformatf("v%0d head1", i), {24'b0, dout1[7:0]}, {24'b0, vecs[i].h1});
            check($sformatf("v%0d ovf1", i), {24'b0, ovf1}, {24'b0, vecs[i].o1});
        end
        event_in = 8'h00;
        event_mask = 8'hFF;
        rd_en = 1'b0;
        clr_overflow = 1'b0;

        // Saturation, then clear coincident with a loss
        event_in = 8'h01;
        repeat (300) step();
        check("sat_ovf0", {24'b0, ovf0}, 255);
        check("sat_ovf1", {24'b0, ovf1}, 255);
        check("sat_full0", {31'b0, full0}, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("clr_hit_ovf0", {24'b0, ovf0}, 1);
        check("clr_hit_ovf1", {24'b0, ovf1}, 1);
        event_in = 8'h00;
        step();
        check("post_clr_ovf0", {24'b0, ovf0}, 2);
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("part_count0", {29'b0, count0}, 3);

        // Asynchronous reset with entries queued
        #2;
        rst_b = 1'b0;
        #1;
        check("arst_empty0", {31'b0, empty0}, 1);
        check("arst_count0", {29'b0, count0}, 0);
        check("arst_dout0", {16'b0, dout0}, 0);
        check("arst_ovf0", {24'b0, ovf0}, 0);
        check("arst_empty1", {31'b0, empty1}, 1);
        rst_b = 1'b1;

        // Timestamp wrap 255 -> 0
        repeat (255) step();
        event_in = 8'h01;
        step();
        event_in = 8'h02;
        step();
        event_in = 8'h00;
        check("wrap_head", {16'b0, dout0}, 32'hFF01);
        check("wrap_count", {29'b0, count0}, 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("wrap_next", {16'b0, dout0}, 32'h0002);
        check("wrap_count2", {29'b0, count0}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_event_queue.md
Name: io_event_queue

Overview:
- Parametrised successor to the top-level button-event capture path (debounced compass/rotary pulses -> FIFO -> CPU).
- Accepts NUM_INPUTS single-cycle event pulses with a per-input enable mask.
- Stamps each event word with a prescaled free-running timestamp and buffers it in a first-word-fall-through queue the CPU drains via rd_en.
- New relative to the existing path: selectable overflow policy (drop-newest / overwrite-oldest), saturating overflow counter, occupancy output.

Parameters:
- NUM_INPUTS, 8, number of event input lines.
- FIFO_DEPTH, 32, queue entries; power of two, >= 2.
- TS_WIDTH, 16, timestamp width in bits.
- TICK_DIV, 50000, clock cycles per timestamp tick (1 ms at 50 MHz); >= 1.
- OVERFLOW_MODE, 0, 0 = drop newest on full, 1 = overwrite oldest on full.

Ports:
- clk  in  1  CPU clock.
- rst_b  in  1  asynchronous active-low reset.
- event_in  in  NUM_INPUTS  single-cycle event pulses, bit i = input i.
- event_mask  in  NUM_INPUTS  1 = input enabled.
- rd_en  in  1  pop head entry; ignored when empty.
- dout  out  TS_WIDTH+NUM_INPUTS  head entry {timestamp, events}; 0 when empty.
- empty  out  1  queue empty.
- full  out  1  count == FIFO_DEPTH.
- count  out  clog2(FIFO_DEPTH)+1  occupancy.
- overflow_count  out  8  saturating count of lost entries.
- clr_overflow  in  1  synchronous clear of overflow_count.

Behaviour:
- Reset (rst_b low, async): empty=1, full=0, count=0, dout=0, overflow_count=0; timestamp, prescaler, pointers and capture register cleared. Storage array not reset. Reset mid-fill discards all entries.
- Timestamp:
  - Prescaler counts 0..TICK_DIV-1.
  - Timestamp increments when prescaler == TICK_DIV-1.
  - Wraps 2^TS_WIDTH-1 -> 0.
- Capture:
  - At each edge, m = event_in & event_mask is registered together with the current timestamp, plus a valid bit = |m.
  - m == 0: nothing enqueued.
  - Multiple simultaneous bits produce one word with all bits set.
- Enqueue: a valid capture is written at the following edge. Latency from event edge to empty=0 / dout valid is 2 edges.
- Read: FWFT. While !empty, dout = head. rd_en && !empty pops at the edge; the next head is visible after that edge.
- Push and pop in the same edge:
  - Not full: count unchanged, both take effect.
  - Full: pop frees the slot, write accepted, no overflow in either mode.
- Full with push and no pop:
  - Mode 0: new word discarded; overflow_count += 1.
  - Mode 1: head discarded, new word written at tail; count stays FIFO_DEPTH; overflow_count += 1.
- overflow_count saturates at 255.
  - clr_overflow alone -> 0.
  - clr_overflow coincident with an overflow -> 1.
- Pointers: log2(FIFO_DEPTH) bits, natural wrap. full/empty derived from the count register, not from pointer comparison.
- rd_en while empty: no effect; count never underflows.

Decomposition:
- Package io_event_pkg:
  - OVF_DROP_NEWEST=0, OVF_OVERWRITE_OLDEST=1.
  - Function for entry width (TS_WIDTH+NUM_INPUTS).
  - Function for count width (clog2(FIFO_DEPTH)+1).
- Sub-module event_fifo_fwft: storage array, pointers, count, full/empty, FWFT head output, overwrite-oldest support.
- Top level holds: prescaler/timestamp, capture register, overflow policy, overflow counter.

Test Plan:
Bench parameters: NUM_INPUTS=8, FIFO_DEPTH=4, TS_WIDTH=8, TICK_DIV=1.
1. Reset and first event: rst_b low -> empty=1, count=0, dout=0. Release; pulse event_in=8'h05, mask=8'hFF while timestamp=3 -> 2 edges later empty=0, count=1, dout=16'h0305. rd_en one cycle -> empty=1, dout=0.
2. Masking and multiple bits: event_in=8'h80, mask=8'h7F -> no enqueue. event_in=8'hC1, mask=8'hFF -> one entry, events=8'hC1.
3. Mode 0 overflow: five events 01,02,04,08,10 with no reads -> full=1 after 4th, overflow_count=1. Reads return 01,02,04,08 in order.
4. Mode 1 overflow: same stimulus -> count=4, overflow_count=1, reads return 02,04,08,10.
5. Full plus simultaneous rd_en and push (mode 0): count stays 4, overflow_count stays 0, popped and pushed words correct.
6. Counter and timestamp edges:
   - 300 overflows -> overflow_count=255.
   - clr_overflow coincident with an overflow -> 1.
   - Timestamp 255 wraps to 0 in a captured word.
   - rst_b asserted mid-fill -> empty=1 immediately, without waiting for a clock edge.
